// File: rtl/cpu_pkg.sv
// Shared types and constants for the lab CPU front end.
package cpu_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Occupancy of the 2-entry fetch buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-to-decode valid/ready handshake carrying {pc, inst}.
interface inst_fetch_if;
    import cpu_pkg::*;

    logic              if_valid;
    logic              if_ready;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;

    modport master (output if_valid, output if_pc, output if_inst, input  if_ready);
    modport slave  (input  if_valid, input  if_pc, input  if_inst, output if_ready);

endinterface

// File: rtl/fetch_buf.sv
// Two-entry fetch FIFO; head is always slot0, flush dominates push/pop.
module fetch_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    buf_state_e   state_q, state_d;
    fetch_entry_t slot0_q, slot0_d;
    fetch_entry_t slot1_q, slot1_d;
    logic         do_pop;
    logic         do_push;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= BUF_EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    // Flush only clears occupancy; slot contents stay so the head holds its last value.
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        do_pop  = pop_i && (state_q != BUF_EMPTY);
        do_push = push_i && ((state_q != BUF_FULL) || do_pop);

        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (do_push) begin
                        slot0_d = entry_i;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (do_push && do_pop) begin
                        slot0_d = entry_i;
                    end else if (do_push) begin
                        slot1_d = entry_i;
                        state_d = BUF_FULL;
                    end else if (do_pop) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (do_pop) begin
                        slot0_d = slot1_q;
                        if (do_push) slot1_d = entry_i;
                        else         state_d = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    assign head_o  = slot0_q;
    assign count_o = state_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the fetch PC, reads the async ROM and feeds decode through fetch_buf.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 5,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    inst_fetch_if.master      dec,
    output logic [PC_W-1:0]   fetch_pc
);

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            pop;
    logic            push;
    logic [1:0]      buf_count;
    fetch_entry_t    buf_head;
    fetch_entry_t    new_entry;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pop  = dec.if_valid && dec.if_ready;
    assign push = !redirect_valid && ((buf_count != 2'd2) || pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) fetch_pc_q <= RESET_PC;
        else         fetch_pc_q <= fetch_pc_d;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        else if (push)      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // ROM index wraps by truncation; no range check on purpose.
    assign rom_addr  = fetch_pc_q[ADDR_W+1:2];
    assign new_entry = '{pc: fetch_pc_q, inst: rom_inst};

    fetch_buf u_buf (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .entry_i (new_entry),
        .head_o  (buf_head),
        .count_o (buf_count)
    );

    assign dec.if_valid = (buf_count != 2'd0);
    assign dec.if_pc    = buf_head.pc;
    assign dec.if_inst  = buf_head.inst;
    assign fetch_pc     = fetch_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed vector table plus stream, and a random-ready scoreboard run for inst_fetch.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [4:0]  rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] fetch_pc;

    int checks = 0;
    int failures = 0;

    inst_fetch_if dif ();

    inst_fetch #(.ADDR_W(5), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dif),
        .fetch_pc       (fetch_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [4:0] a);
        case (a)
            5'd0:  rom_word = 32'h24010001;
            5'd1:  rom_word = 32'h00011100;
            5'd2:  rom_word = 32'h00411821;
            5'd3:  rom_word = 32'h00622021;
            5'd4:  rom_word = 32'h00832821;
            5'd5:  rom_word = 32'h00A43021;
            5'd6:  rom_word = 32'h00C53821;
            5'd7:  rom_word = 32'h00E64021;
            5'd8:  rom_word = 32'h01074821;
            5'd9:  rom_word = 32'h01285021;
            5'd10: rom_word = 32'h01495821;
            5'd11: rom_word = 32'h016A6021;
            5'd12: rom_word = 32'h018B6821;
            5'd13: rom_word = 32'h8C2A0013;
            5'd14: rom_word = 32'h15450003;
            5'd15: rom_word = 32'h01AC7021;
            5'd16: rom_word = 32'h01CD7821;
            5'd17: rom_word = 32'h01EE8021;
            5'd18: rom_word = 32'h020F8821;
            5'd19: rom_word = 32'h08000000;
            5'd31: rom_word = 32'hDEADBEEF;
            default: rom_word = 32'h00000000;
        endcase
    endfunction

    assign rom_inst = rom_word(rom_addr);

    typedef struct {
        logic        rstn;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] fpc;
        logic [4:0]  addr;
    } vec_t;

    function automatic vec_t mk(input logic rstn, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic v, input logic [31:0] pc,
                                input logic [31:0] inst, input logic [31:0] fpc,
                                input logic [4:0] addr);
        vec_t r;
        r.rstn = rstn; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
        r.v = v; r.pc = pc; r.inst = inst; r.fpc = fpc; r.addr = addr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t        vt [25];
    logic [31:0] exp_pc;
    logic [31:0] held_pc;
    logic        held;
    logic        rdy_r;
    logic        rv_r;
    logic [31:0] rpc_r;
    int          delivered;

    initial begin
        dif.if_ready = 1'b0;
        // rstn rdy rv rpc | v pc inst fpc addr  (outputs observed during the row's cycle)
        vt[0]  = mk(0, 0, 0, 32'h0,  0, 32'h00, 32'h00000000, 32'h00, 5'd0);
        vt[1]  = mk(1, 1, 0, 32'h0,  0, 32'h00, 32'h00000000, 32'h00, 5'd0);
        vt[2]  = mk(1, 1, 0, 32'h0,  1, 32'h00, 32'h24010001, 32'h04, 5'd1);
        vt[3]  = mk(1, 1, 0, 32'h0,  1, 32'h04, 32'h00011100, 32'h08, 5'd2);
        vt[4]  = mk(1, 1, 0, 32'h0,  1, 32'h08, 32'h00411821, 32'h0C, 5'd3);
        vt[5]  = mk(0, 0, 0, 32'h0,  0, 32'h00, 32'h00000000, 32'h00, 5'd0);
        vt[6]  = mk(1, 0, 0, 32'h0,  0, 32'h00, 32'h00000000, 32'h00, 5'd0);
        vt[7]  = mk(1, 0, 0, 32'h0,  1, 32'h00, 32'h24010001, 32'h04, 5'd1);
        vt[8]  = mk(1, 0, 0, 32'h0,  1, 32'h00, 32'h24010001, 32'h08, 5'd2);
        vt[9]  = mk(1, 0, 0, 32'h0,  1, 32'h00, 32'h24010001, 32'h08, 5'd2);
        vt[10] = mk(1, 0, 0, 32'h0,  1, 32'h00, 32'h24010001, 32'h08, 5'd2);
        vt[11] = mk(1, 1, 0, 32'h0,  1, 32'h00, 32'h24010001, 32'h08, 5'd2);
        vt[12] = mk(1, 1, 0, 32'h0,  1, 32'h04, 32'h00011100, 32'h0C, 5'd3);
        vt[13] = mk(1, 1, 0, 32'h0,  1, 32'h08, 32'h00411821, 32'h10, 5'd4);
        vt[14] = mk(1, 1, 1, 32'h36, 1, 32'h0C, 32'h00622021, 32'h14, 5'd5);
        vt[15] = mk(1, 1, 0, 32'h0,  0, 32'h0C, 32'h00622021, 32'h34, 5'd13);
        vt[16] = mk(1, 1, 0, 32'h0,  1, 32'h34, 32'h8C2A0013, 32'h38, 5'd14);
        vt[17] = mk(1, 1, 1, 32'h7C, 1, 32'h38, 32'h15450003, 32'h3C, 5'd15);
        vt[18] = mk(1, 1, 0, 32'h0,  0, 32'h38, 32'h15450003, 32'h7C, 5'd31);
        vt[19] = mk(1, 1, 0, 32'h0,  1, 32'h7C, 32'hDEADBEEF, 32'h80, 5'd0);
        vt[20] = mk(1, 1, 0, 32'h0,  1, 32'h80, 32'h24010001, 32'h84, 5'd1);
        vt[21] = mk(1, 0, 0, 32'h0,  1, 32'h84, 32'h00011100, 32'h88, 5'd2);
        vt[22] = mk(0, 0, 0, 32'h0,  0, 32'h00, 32'h00000000, 32'h00, 5'd0);
        vt[23] = mk(1, 1, 0, 32'h0,  0, 32'h00, 32'h00000000, 32'h00, 5'd0);
        vt[24] = mk(1, 1, 0, 32'h0,  1, 32'h00, 32'h24010001, 32'h04, 5'd1);

        #1;
        for (int i = 0; i < 25; i++) begin
            resetn         = vt[i].rstn;
            dif.if_ready   = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            #1;
            chk($sformatf("row%0d if_valid", i), {31'b0, dif.if_valid}, {31'b0, vt[i].v});
            chk($sformatf("row%0d if_pc", i), dif.if_pc, vt[i].pc);
            chk($sformatf("row%0d if_inst", i), dif.if_inst, vt[i].inst);
            chk($sformatf("row%0d fetch_pc", i), fetch_pc, vt[i].fpc);
            chk($sformatf("row%0d rom_addr", i), {27'b0, rom_addr}, {27'b0, vt[i].addr});
            step();
        end
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Continuous stream after the restart: outputs 2..20 back to back.
        dif.if_ready = 1'b1;
        for (int k = 2; k <= 20; k++) begin
            chk($sformatf("stream%0d if_valid", k), {31'b0, dif.if_valid}, 32'd1);
            chk($sformatf("stream%0d if_pc", k), dif.if_pc, 32'(4 * (k - 1)));
            if (k == 20) chk("stream20 if_inst", dif.if_inst, 32'h08000000);
            step();
        end

        // Random backpressure with occasional redirects; scoreboard on accepted entries.
        exp_pc    = 32'h50;
        held      = 1'b0;
        held_pc   = 32'h0;
        delivered = 0;
        for (int c = 0; c < 200; c++) begin
            rdy_r = 1'($urandom_range(0, 1));
            rv_r  = ($urandom_range(0, 15) == 0);
            rpc_r = 32'($urandom_range(0, 255));
            dif.if_ready   = rdy_r;
            redirect_valid = rv_r;
            redirect_pc    = rpc_r;
            #1;
            if (held) begin
                chk("hold if_valid", {31'b0, dif.if_valid}, 32'd1);
                chk("hold if_pc", dif.if_pc, held_pc);
            end
            if (dif.if_valid && rdy_r && !rv_r) begin
                chk("sb if_pc", dif.if_pc, exp_pc);
                chk("sb if_inst", dif.if_inst, rom_word(exp_pc[6:2]));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            held    = dif.if_valid && !rdy_r && !rv_r;
            held_pc = dif.if_pc;
            step();
            if (rv_r) exp_pc = {rpc_r[31:2], 2'b00};
        end
        chk("sb delivered>=20", {31'b0, (delivered >= 20)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: the initiator that reads the asynchronous instruction ROM. It holds the fetch PC and drives the ROM word address. It captures the combinationally returned instruction into a 2-entry buffer and hands {pc, inst} to decode over a valid/ready handshake. It sits between the instruction ROM and the decode stage of the single-issue lab CPU, and accepts branch/jump redirects from execute.

## Interface
- `ADDR_W`, 5: ROM word-address width. ROM address = `fetch_pc[ADDR_W+1:2]`.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset.
- `clk`  in  1: single clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `rom_addr`  out  ADDR_W: word address to the instruction ROM.
- `rom_inst`  in  32: ROM data, combinational function of `rom_addr` in the same cycle.
- `redirect_valid`  in  1: one-cycle pulse; load the new fetch PC.
- `redirect_pc`  in  32: redirect target; bits [1:0] are ignored and forced to 0.
- `if_valid`  out  1: buffer head is valid.
- `if_ready`  in  1: decode accepts the head this cycle.
- `if_pc`  out  32: PC of the head instruction.
- `if_inst`  out  32: head instruction word.
- `fetch_pc`  out  32: current fetch PC, for debug.

## Operation
- State: `fetch_pc` register, plus a 2-entry FIFO of {pc, inst} with a count of 0..2.
- `rom_addr` = `fetch_pc[ADDR_W+1:2]` at all times. This is combinational from the register.
- pop = `if_valid && if_ready`.
- push = `!redirect_valid && (count < 2 || pop)`.
- On push: enqueue {`fetch_pc`, `rom_inst`}, and `fetch_pc <= fetch_pc + 4`.
- A redirect has priority over push and pop:
  - the FIFO is flushed (count <= 0, all entries discarded, including one being popped that cycle);
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`;
  - no enqueue occurs that cycle.
- Simultaneous pop and push at count 2 is legal. Count stays 2 and FIFO order is preserved.
- `fetch_pc` increments modulo 2^32. `rom_addr` wraps naturally by truncation, so PC 0x7C → addr 31 and PC 0x80 → addr 0.
- No alignment or range check beyond truncation. The ROM content at unpopulated addresses is passed through unchanged.
- `if_valid` = (count != 0). `if_pc` and `if_inst` come from the head entry. When `if_valid`=0 they hold their last value (not X).

## Timing
- Reset (asynchronous assert; deassert is sampled at `clk`) sets:
  - `fetch_pc`=RESET_PC, count=0, `if_valid`=0;
  - `if_pc`=0, `if_inst`=0, storage zeroed;
  - `rom_addr`=RESET_PC[ADDR_W+1:2].
- Reset mid-operation discards all buffered entries immediately, with no clock needed.
- Fetch-to-output latency is 1 cycle. An instruction pushed at edge N is visible on `if_*` with `if_valid`=1 after edge N.
- First instruction: at the first edge with `resetn` high, PC RESET_PC is pushed. `if_valid` rises after that edge.
- Redirect sampled at edge N:
  - `if_valid`=0 during cycle N+1;
  - the target is pushed at edge N+1;
  - the target is presented after edge N+1.
  - Bubble is exactly 1 cycle.
- Steady state with `if_ready`=1: one instruction per cycle, with `if_valid` continuously high.
- Backpressure:
  - while `if_valid`=1 and `if_ready`=0, `if_pc`/`if_inst` are stable;
  - `fetch_pc` stops advancing once count=2.
- Throughput returns to 1/cycle on the first cycle `if_ready`=1, with no bubble.

## Structure
- Shared package `cpu_pkg`:
  - `PC_W`=32, `INST_W`=32;
  - `RESET_PC` default;
  - typedef `fetch_entry_t` {pc, inst}.
- Sub-module `fetch_buf`: 2-entry synchronous FIFO of `fetch_entry_t`.
  - Inputs: push, pop, flush (flush dominant), with asynchronous active-low reset.
  - Outputs: head, count.
- `inst_fetch` top owns `fetch_pc`, the push/redirect logic and the ROM address generation.

## Test plan
- Reset, then `if_ready`=1 with the standard program ROM → `if_pc`/`if_inst` = 0x00/24010001, 0x04/00011100, 0x08/00411821, … on consecutive cycles, and 0x4C/08000000 at the 20th output.
- Hold `if_ready`=0 for 4 cycles after the first valid:
  - `if_pc` stays 0x00;
  - count reaches 2;
  - `fetch_pc` stalls at 0x08.
  - Release → 0x00, 0x04, 0x08 delivered back to back with no bubble.
- Pulse `redirect_valid` with `redirect_pc`=0x36 while count=2 and a pop is occurring:
  - the buffer is flushed;
  - one cycle of `if_valid`=0;
  - then 0x34/8C2A0013, 0x38/15450003.
- Redirect to 0x7C → `rom_addr`=31, then `fetch_pc`=0x80 with `rom_addr`=0. `if_pc` reports 0x7C then 0x80.
- Assert `resetn`=0 asynchronously mid-cycle with count=2 →
  - `if_valid`=0 and `fetch_pc`=RESET_PC immediately;
  - after release, the sequence restarts at 0x00/24010001.
- Random `if_ready` (50%) for 200 cycles with a scoreboard → no instruction is dropped or duplicated, and PCs are strictly +4 except after a redirect.
